universal_shift_reg: RTL and testbench

Parametrised successor to the 4-bit parallel-in/parallel-out register: a WIDTH-bit register with eight mode-selected operations (hold, load, logical/arithmetic shifts, rotates, clear). It also has a built-in auto-serializer FSM that loads a word and streams it out one bit per clock with busy/done status. It sits between parallel datapath logic and serial links, and replaces fixed-function PIPO/SIPO/PISO instances.

---
 rtl/universal_shift_reg_if.sv | 26 ++
 rtl/universal_shift_reg.sv | 103 ++++++++++
 tb/tb_universal_shift_reg.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: mode/data/serial inputs from the
// datapath, register contents and serializer status back to it.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in_left;
  logic             serial_in_right;
  logic             start;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_left;
  logic             serial_out_right;
  logic             busy;
  logic             done;

  modport master (
    output mode, parallel_in, serial_in_left, serial_in_right, start,
    input  parallel_out, serial_out_left, serial_out_right, busy, done
  );

  modport slave (
    input  mode, parallel_in, serial_in_left, serial_in_right, start,
    output parallel_out, serial_out_left, serial_out_right, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with eight mode operations and an
// auto-serializer that streams a loaded word out one bit per clock.
module universal_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  universal_shift_reg_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  logic [WIDTH-1:0] reg_q,   reg_d;
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state logic: start wins over mode while idle; the shift phase ignores both.
  always_comb begin
    reg_d   = reg_q;
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          reg_d   = bus.parallel_in;
          count_d = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          case (bus.mode)
            MODE_HOLD: reg_d = reg_q;
            MODE_LOAD: reg_d = bus.parallel_in;
            MODE_SHR:  reg_d = {bus.serial_in_left, reg_q[WIDTH-1:1]};
            MODE_SHL:  reg_d = {reg_q[WIDTH-2:0], bus.serial_in_right};
            MODE_ROR:  reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
            MODE_ROL:  reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
            MODE_ASR:  reg_d = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
            MODE_CLR:  reg_d = {WIDTH{1'b0}};
            default:   reg_d = reg_q;
          endcase
        end
      end
      ST_SHIFT: begin
        // The last bit is already on the serial output, so the final cycle holds.
        if (count_q != {CW{1'b0}}) begin
          if (LSB_FIRST) begin
            reg_d = {bus.serial_in_left, reg_q[WIDTH-1:1]};
          end else begin
            reg_d = {reg_q[WIDTH-2:0], bus.serial_in_right};
          end
          count_d = count_q - CW'(1);
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_q   <= {WIDTH{1'b0}};
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.parallel_out     = reg_q;
  assign bus.serial_out_left  = reg_q[WIDTH-1];
  assign bus.serial_out_right = reg_q[0];
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench: table of mode vectors plus serializer sequences on an
// LSB-first instance (a) and an MSB-first instance (b) sharing the same inputs.
module tb_universal_shift_reg;
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef struct packed {
    logic [2:0] mode;
    logic [7:0] pin;
    logic       sil;
    logic       sir;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] pin = 8'h00;
  logic       sil = 1'b0;
  logic       sir = 1'b0;
  logic       start = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic       sb_r[$];
  logic       sb_l[$];
  vec_t       vt[20];

  universal_shift_reg_if #(.WIDTH(8)) if_a ();
  universal_shift_reg_if #(.WIDTH(8)) if_b ();

  assign if_a.mode = mode;            assign if_b.mode = mode;
  assign if_a.parallel_in = pin;      assign if_b.parallel_in = pin;
  assign if_a.serial_in_left = sil;   assign if_b.serial_in_left = sil;
  assign if_a.serial_in_right = sir;  assign if_b.serial_in_right = sir;
  assign if_a.start = start;          assign if_b.start = start;

  universal_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .clock(clk), .reset(rst_n), .bus(if_a.slave));
  universal_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clock(clk), .reset(rst_n), .bus(if_b.slave));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serialize word w on both instances; optionally poke mode=CLR/start mid-run.
  task automatic run_ser(input logic [7:0] w, input bit disturb);
    @(negedge clk);
    start = 1'b1; pin = w; mode = M_HOLD; sil = 1'b0; sir = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sb_r.push_back(w[k]);
      sb_l.push_back(w[7-k]);
    end
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (disturb && (k == 2 || k == 3)) begin
        mode = M_CLR; start = 1'b1;
      end else begin
        mode = M_HOLD; start = 1'b0;
      end
      check($sformatf("ser_r bit%0d", k), 64'(if_a.serial_out_right), 64'(sb_r.pop_front()));
      check($sformatf("ser_l bit%0d", k), 64'(if_b.serial_out_left), 64'(sb_l.pop_front()));
      check($sformatf("busy k%0d", k), 64'({if_a.busy, if_b.busy, if_a.done}), 64'(3'b110));
      tick();
    end
    mode = M_HOLD; start = 1'b0;
    check("done pulse", 64'({if_a.busy, if_a.done, if_b.busy, if_b.done}), 64'(4'b0101));
    tick();
    check("done clears", 64'({if_a.busy, if_a.done, if_b.busy, if_b.done}), 64'(4'b0000));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{M_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vt[1]  = '{M_HOLD, 8'h00, 1'b1, 1'b1, 8'hA5};
    vt[2]  = '{M_HOLD, 8'hFF, 1'b0, 1'b0, 8'hA5};
    vt[3]  = '{M_HOLD, 8'h3C, 1'b1, 1'b0, 8'hA5};
    vt[4]  = '{M_SHR,  8'h00, 1'b0, 1'b1, 8'h52};
    vt[5]  = '{M_LOAD, 8'h96, 1'b0, 1'b0, 8'h96};
    vt[6]  = '{M_ASR,  8'h00, 1'b0, 1'b0, 8'hCB};
    vt[7]  = '{M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
    vt[8]  = '{M_ROL,  8'h00, 1'b0, 1'b0, 8'h03};
    vt[9]  = '{M_LOAD, 8'h0F, 1'b0, 1'b0, 8'h0F};
    vt[10] = '{M_SHL,  8'h00, 1'b0, 1'b1, 8'h1F};
    vt[11] = '{M_CLR,  8'hFF, 1'b1, 1'b1, 8'h00};
    vt[12] = '{M_SHR,  8'h00, 1'b1, 1'b0, 8'h80};
    vt[13] = '{M_ROR,  8'h00, 1'b0, 1'b0, 8'h40};
    vt[14] = '{M_ASR,  8'h00, 1'b1, 1'b1, 8'h20};
    vt[15] = '{M_LOAD, 8'h01, 1'b0, 1'b0, 8'h01};
    vt[16] = '{M_ROR,  8'h00, 1'b0, 1'b0, 8'h80};
    vt[17] = '{M_ASR,  8'h00, 1'b0, 1'b0, 8'hC0};
    vt[18] = '{M_SHL,  8'h00, 1'b1, 1'b0, 8'h80};
    vt[19] = '{M_ROL,  8'h00, 1'b0, 1'b0, 8'h01};

    #12;
    check("reset po_a", 64'(if_a.parallel_out), 64'(8'h00));
    check("reset status", 64'({if_a.busy, if_a.done, if_b.busy, if_b.done}), 64'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      logic [7:0] e;
      @(negedge clk);
      mode = vt[i].mode; pin = vt[i].pin; sil = vt[i].sil; sir = vt[i].sir;
      exp_q.push_back(vt[i].exp);
      tick();
      e = exp_q.pop_front();
      check($sformatf("vec%0d po_a", i), 64'(if_a.parallel_out), 64'(e));
      check($sformatf("vec%0d po_b", i), 64'(if_b.parallel_out), 64'(e));
      check($sformatf("vec%0d sol/sor", i),
            64'({if_a.serial_out_left, if_a.serial_out_right}), 64'({e[7], e[0]}));
    end

    run_ser(8'b1100_1010, 1'b0);
    run_ser(8'b1100_1010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("no rerun %0d", k), 64'({if_a.busy, if_b.busy}), 64'(2'b00));
    end

    // Reset pulled in the middle of a run clears everything immediately.
    @(negedge clk);
    start = 1'b1; pin = 8'hFF; mode = M_HOLD;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid-run busy", 64'(if_a.busy), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    check("async rst po", 64'({if_a.parallel_out, if_b.parallel_out}), 64'(16'h0000));
    check("async rst status", 64'({if_a.busy, if_a.done, if_b.busy, if_b.done}), 64'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    run_ser(8'h3C, 1'b0);

    // Start held high: next run is accepted on the edge where done is high.
    @(negedge clk);
    start = 1'b1; pin = 8'h5A; mode = M_HOLD;
    for (int k = 0; k < 9; k++) tick();
    check("b2b done", 64'({if_a.busy, if_a.done}), 64'(2'b01));
    tick();
    check("b2b restart", 64'({if_a.busy, if_a.done, if_a.serial_out_right}), 64'(3'b100));
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("b2b idle", 64'({if_a.busy, if_a.done}), 64'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
